// File: rtl/pulse_gen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pulse_gen_multi                                                  |
// | Brief   : multi-channel periodic/one-shot pulse generator with shadow cfg   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pulse_gen_multi #(
  parameter int  CH_NUM      = 4,
  parameter int  CNT_W       = 10,
  parameter int  DEF_PERIOD  = 659,
  parameter int  DEF_HIGH    = 219,
  parameter bit  DEF_ONESHOT = 1'b0,
  localparam int CH_IDX_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CH_NUM-1:0]   i_en,
  input  logic [CH_NUM-1:0]   i_trig,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [CH_IDX_W-1:0] i_cfg_ch,
  input  logic [CNT_W-1:0]    i_cfg_period,
  input  logic [CNT_W-1:0]    i_cfg_high,
  input  logic                i_cfg_oneshot,
  output logic [CH_NUM-1:0]   o_pulse,
  output logic [CH_NUM-1:0]   o_period_end,
  output logic [CH_NUM-1:0]   o_busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_DEF_PERIOD = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] C_DEF_HIGH   = CNT_W'(DEF_HIGH);

  logic [CH_NUM-1:0] w_pend;

  // Out-of-range channel numbers never match, so they stay ready and are dropped.
  always_comb begin
    o_cfg_ready = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      if (i_cfg_ch == CH_IDX_W'(i)) o_cfg_ready = !w_pend[i];
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d, high_q, high_d;
    logic [CNT_W-1:0] sh_per_q, sh_per_d, sh_high_q, sh_high_d;
    logic             os_q, os_d, sh_os_q, sh_os_d;
    logic             pend_q, pend_d, pulse_q, pulse_d;
    logic [CNT_W-1:0] w_last;
    logic             w_at_end, w_copy, w_accept;

    always_comb begin
      // A zero period behaves as period 1.
      w_last   = (per_q == '0) ? '0 : per_q - 1'b1;
      w_at_end = (state_q == ST_RUN) && (cnt_q == w_last);
      w_accept = i_cfg_valid && (i_cfg_ch == CH_IDX_W'(i)) && !pend_q;
      w_copy   = pend_q && ((state_q == ST_IDLE) || w_at_end);

      state_d   = state_q;
      cnt_d     = '0;
      per_d     = per_q;
      high_d    = high_q;
      os_d      = os_q;
      sh_per_d  = sh_per_q;
      sh_high_d = sh_high_q;
      sh_os_d   = sh_os_q;
      pend_d    = pend_q;

      if (state_q == ST_RUN) begin
        if (!i_en[i]) begin
          state_d = ST_IDLE;
        end else if (w_at_end) begin
          // One-shot ends here, including a mode switch landing on this boundary.
          if (os_q || (pend_q && sh_os_q)) state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (i_en[i] && (!os_q || i_trig[i])) begin
        state_d = ST_RUN;
      end

      if (w_copy) begin
        per_d  = sh_per_q;
        high_d = sh_high_q;
        os_d   = sh_os_q;
        pend_d = 1'b0;
      end
      if (w_accept) begin
        sh_per_d  = i_cfg_period;
        sh_high_d = i_cfg_high;
        sh_os_d   = i_cfg_oneshot;
        pend_d    = 1'b1;
      end

      pulse_d = (state_d == ST_RUN) && (cnt_d < high_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        per_q     <= C_DEF_PERIOD;
        high_q    <= C_DEF_HIGH;
        os_q      <= DEF_ONESHOT;
        sh_per_q  <= C_DEF_PERIOD;
        sh_high_q <= C_DEF_HIGH;
        sh_os_q   <= DEF_ONESHOT;
        pend_q    <= 1'b0;
        pulse_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        per_q     <= per_d;
        high_q    <= high_d;
        os_q      <= os_d;
        sh_per_q  <= sh_per_d;
        sh_high_q <= sh_high_d;
        sh_os_q   <= sh_os_d;
        pend_q    <= pend_d;
        pulse_q   <= pulse_d;
      end
    end

    assign w_pend[i]       = pend_q;
    assign o_pulse[i]      = pulse_q;
    assign o_period_end[i] = w_at_end;
    assign o_busy[i]       = (state_q == ST_RUN);
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pulse_gen_multi                                               |
// | Brief   : self-checking bench for pulse_gen_multi                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pulse_gen_multi;

  localparam int CH    = 4;
  localparam int W     = 10;
  localparam int IDX_W = 2;
  localparam int DEFP  = 659;
  localparam int DEFH  = 219;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [CH-1:0]    i_en = '0;
  logic [CH-1:0]    i_trig = '0;
  logic             i_cfg_valid = 1'b0;
  logic             o_cfg_ready;
  logic [IDX_W-1:0] i_cfg_ch = '0;
  logic [W-1:0]     i_cfg_period = '0;
  logic [W-1:0]     i_cfg_high = '0;
  logic             i_cfg_oneshot = 1'b0;
  logic [CH-1:0]    o_pulse, o_period_end, o_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  pulse_gen_multi #(.CH_NUM(CH), .CNT_W(W), .DEF_PERIOD(DEFP), .DEF_HIGH(DEFH),
                    .DEF_ONESHOT(1'b0)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_trig(i_trig),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_ch(i_cfg_ch),
    .i_cfg_period(i_cfg_period), .i_cfg_high(i_cfg_high),
    .i_cfg_oneshot(i_cfg_oneshot), .o_pulse(o_pulse),
    .o_period_end(o_period_end), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position within the period of each running channel, plus the
  // active and staged settings as plain integers.
  int m_run[CH], m_pos[CH], m_per[CH], m_high[CH], m_os[CH];
  int s_per[CH], s_high[CH], s_os[CH], m_pend[CH];

  function automatic int eff_len(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_run[c] = 0; m_pos[c] = 0; m_pend[c] = 0;
        m_per[c] = DEFP; m_high[c] = DEFH; m_os[c] = 0;
        s_per[c] = DEFP; s_high[c] = DEFH; s_os[c] = 0;
      end
    end else begin
      cyc++;
      for (int c = 0; c < CH; c++) begin
        automatic bit last  = m_run[c] != 0 && m_pos[c] == eff_len(m_per[c]) - 1;
        automatic bit take  = i_cfg_valid && int'(i_cfg_ch) == c && m_pend[c] == 0;
        automatic bit apply = m_pend[c] != 0 && (m_run[c] == 0 || last);
        automatic int next_os = apply ? s_os[c] : m_os[c];
        if (m_run[c] != 0) begin
          if (!i_en[c]) begin
            m_run[c] = 0; m_pos[c] = 0;
          end else if (last) begin
            if (m_os[c] != 0 || next_os != 0) m_run[c] = 0;
            m_pos[c] = 0;
          end else begin
            m_pos[c] = m_pos[c] + 1;
          end
        end else if (i_en[c] && (m_os[c] == 0 || i_trig[c])) begin
          m_run[c] = 1; m_pos[c] = 0;
        end
        if (apply) begin
          m_per[c] = s_per[c]; m_high[c] = s_high[c]; m_os[c] = s_os[c]; m_pend[c] = 0;
        end
        if (take) begin
          s_per[c] = int'(i_cfg_period); s_high[c] = int'(i_cfg_high);
          s_os[c] = int'(i_cfg_oneshot); m_pend[c] = 1;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      automatic logic [CH-1:0] e_p = '0, e_e = '0, e_b = '0;
      automatic int e_r = 1;
      for (int c = 0; c < CH; c++) begin
        e_b[c] = m_run[c] != 0;
        e_p[c] = m_run[c] != 0 && m_pos[c] < m_high[c];
        e_e[c] = m_run[c] != 0 && m_pos[c] == eff_len(m_per[c]) - 1;
      end
      if (int'(i_cfg_ch) < CH) e_r = (m_pend[i_cfg_ch] == 0) ? 1 : 0;
      chk("cyc_pulse", int'(o_pulse), int'(e_p));
      chk("cyc_period_end", int'(o_period_end), int'(e_e));
      chk("cyc_busy", int'(o_busy), int'(e_b));
      chk("cyc_cfg_ready", int'(o_cfg_ready), e_r);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic wait_pe(input int ch, input int limit);
    int n = 0;
    while (!o_period_end[ch] && n < limit) begin
      tick(1);
      n++;
    end
    if (n >= limit) chk("timeout_period_end", 0, 1);
  endtask

  task automatic cfg(input int ch, input int per, input int hi, input bit os);
    i_cfg_valid = 1'b1; i_cfg_ch = IDX_W'(ch);
    i_cfg_period = W'(per); i_cfg_high = W'(hi); i_cfg_oneshot = os;
    tick(1);
    i_cfg_valid = 1'b0;
  endtask

  task automatic count(input int ch, input int n, output int hi, output int pe, output int bz);
    hi = 0; pe = 0; bz = 0;
    repeat (n) begin
      hi += int'(o_pulse[ch]); pe += int'(o_period_end[ch]); bz += int'(o_busy[ch]);
      tick(1);
    end
  endtask

  initial begin
    int hi, pe, bz, c0;
    #1;
    chk("rst_pulse", int'(o_pulse), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_period_end", int'(o_period_end), 0);
    chk("rst_ready", int'(o_cfg_ready), 1);
    tick(2);
    i_rst_n = 1'b1;
    tick(1);

    // Defaults on ch0: 219 high, 440 low, one strobe per 659 cycles.
    i_en[0] = 1'b1;
    tick(1);
    chk("t1_first_pulse", int'(o_pulse[0]), 1);
    count(0, 2 * DEFP, hi, pe, bz);
    chk("t1_high_cycles", hi, 2 * DEFH);
    chk("t1_strobes", pe, 2);

    // One-shot ch1.
    cfg(1, 10, 3, 1'b1);
    i_cfg_ch = 2'd1;
    #1 chk("t2_ready_pending", int'(o_cfg_ready), 0);
    tick(1);
    i_en[1] = 1'b1; i_trig[1] = 1'b1;
    tick(1);
    i_trig[1] = 1'b0;
    count(1, 16, hi, pe, bz);
    chk("t2_busy_cycles", bz, 10);
    chk("t2_high_cycles", hi, 3);
    chk("t2_strobes", pe, 1);
    i_en[1] = 1'b0;

    // Mid-period reconfiguration of ch0.
    wait_pe(0, 1000);
    c0 = cyc;
    tick(50);
    cfg(0, 20, 5, 1'b0);
    i_cfg_valid = 1'b1; i_cfg_ch = 2'd0; i_cfg_period = W'(30); i_cfg_high = W'(7);
    #1 chk("t3_second_cfg_blocked", int'(o_cfg_ready), 0);
    tick(3);
    i_cfg_valid = 1'b0;
    wait_pe(0, 1000);
    chk("t3_old_period_len", cyc - c0, DEFP);
    tick(1);
    #1 chk("t3_ready_after_copy", int'(o_cfg_ready), 1);
    count(0, 20, hi, pe, bz);
    chk("t3_new_high", hi, 5);
    chk("t3_new_strobes", pe, 1);

    // Corner values on ch3.
    cfg(3, 8, 0, 1'b0);
    tick(1);
    i_en[3] = 1'b1;
    tick(1);
    count(3, 16, hi, pe, bz);
    chk("t4_high0_pulse", hi, 0);
    chk("t4_high0_strobes", pe, 2);
    cfg(3, 8, 8, 1'b0);
    wait_pe(3, 20); tick(1); wait_pe(3, 20); tick(1);
    count(3, 16, hi, pe, bz);
    chk("t4_high_eq_period", hi, 16);
    cfg(3, 0, 0, 1'b0);
    wait_pe(3, 20); tick(1); wait_pe(3, 20); tick(1);
    count(3, 10, hi, pe, bz);
    chk("t4_period0_strobes", pe, 10);

    // Abort ch2 at cnt=100 and restart.
    i_en[2] = 1'b1;
    tick(1);
    tick(100);
    i_en[2] = 1'b0;
    tick(1);
    chk("t5_abort_pulse", int'(o_pulse[2]), 0);
    chk("t5_abort_busy", int'(o_busy[2]), 0);
    chk("t5_abort_strobe", int'(o_period_end[2]), 0);
    i_en[2] = 1'b1;
    tick(1);
    chk("t5_restart_busy", int'(o_busy[2]), 1);
    chk("t5_restart_pulse", int'(o_pulse[2]), 1);

    // Asynchronous reset with a pending config on ch0.
    cfg(0, 50, 10, 1'b0);
    tick(3);
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_pulse", int'(o_pulse), 0);
    chk("t6_rst_busy", int'(o_busy), 0);
    chk("t6_rst_strobe", int'(o_period_end), 0);
    i_cfg_ch = 2'd0;
    #1 chk("t6_rst_ready", int'(o_cfg_ready), 1);
    tick(2);
    i_rst_n = 1'b1;
    tick(1);
    count(0, DEFP, hi, pe, bz);
    chk("t6_default_high", hi, DEFH);
    chk("t6_default_strobes", pe, 1);
    chk("t6_default_busy", bz, DEFP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
